// File: rtl/smi_frame_steer_x2.sv
// smi_frame_steer_x2
// Two-way SMI frame steering block. Each incoming frame is routed as a whole
// to output port A or B. The destination comes from one data bit of the first
// flit (the header). The datapath has one holding stage followed by one output
// stage per port. A stalled port can only hold back the input side; the other
// port keeps draining on its own.

module smi_frame_steer_x2 #(
    parameter int FlitWidth = 2,
    parameter int EofcMask  = 2 * FlitWidth - 1,
    parameter int SelectBit = 0
) (
    input  logic                   clk,
    input  logic                   arstn,

    input  logic                   smiInReady,
    input  logic [7:0]             smiInEofc,
    input  logic [FlitWidth*8-1:0] smiInData,
    output logic                   smiInStop,

    output logic                   smiOutAReady,
    output logic [7:0]             smiOutAEofc,
    output logic [FlitWidth*8-1:0] smiOutAData,
    input  logic                   smiOutAStop,

    output logic                   smiOutBReady,
    output logic [7:0]             smiOutBEofc,
    output logic [FlitWidth*8-1:0] smiOutBData,
    input  logic                   smiOutBStop,

    output logic [15:0]            frameCountA,
    output logic [15:0]            frameCountB
);

    localparam int         DataWidth    = FlitWidth * 8;
    localparam logic [7:0] EofcMaskBits = 8'(EofcMask);

    // Header: the next held flit starts a frame, and its data picks the port.
    // FwdA/FwdB: the rest of the frame goes to the same port, whatever its data.
    typedef enum logic [1:0] {
        Header = 2'b00,
        FwdA   = 2'b01,
        FwdB   = 2'b10
    } state_t;

    state_t stateR;
    state_t stateNextS;

    // Holding stage
    logic                 holdReadyR;
    logic                 holdLastR;
    logic [7:0]           holdEofcR;
    logic [DataWidth-1:0] holdDataR;

    // Output stages
    logic                 outAReadyR;
    logic [7:0]           outAEofcR;
    logic [DataWidth-1:0] outADataR;
    logic                 outBReadyR;
    logic [7:0]           outBEofcR;
    logic [DataWidth-1:0] outBDataR;

    logic [15:0]          frameCountAR;
    logic [15:0]          frameCountBR;

    // Control terms
    logic steerAS;     // the held flit goes to port A (otherwise port B)
    logic haltS;       // the selected output stage is full and stopped
    logic stallS;      // the holding stage must keep its content
    logic acceptS;     // the held flit moves into its output stage this cycle
    logic loadAS;      // output stage A may be overwritten
    logic loadBS;      // output stage B may be overwritten
    logic pushAS;      // a valid flit is written into stage A
    logic pushBS;      // a valid flit is written into stage B

    // Port selection for the held flit, based on the frame position
    always_comb begin
        steerAS = 1'b0;
        case (stateR)
            Header:  steerAS = ~holdDataR[SelectBit];
            FwdA:    steerAS = 1'b1;
            FwdB:    steerAS = 1'b0;
            default: steerAS = 1'b0;
        endcase
    end

    // Stall and load decisions. These use only registers and downstream Stop,
    // so no combinational path runs from the input to smiInStop.
    always_comb begin
        haltS = 1'b0;
        if (steerAS) begin
            haltS = outAReadyR & smiOutAStop;
        end else begin
            haltS = outBReadyR & smiOutBStop;
        end
        stallS  = holdReadyR & haltS;
        acceptS = holdReadyR & ~haltS;
        loadAS  = ~(outAReadyR & smiOutAStop);
        loadBS  = ~(outBReadyR & smiOutBStop);
        pushAS  = loadAS & holdReadyR &  steerAS;
        pushBS  = loadBS & holdReadyR & ~steerAS;
    end

    // Next frame-position state; it moves only when a held flit is accepted
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            Header: begin
                if (acceptS && !holdLastR) begin
                    stateNextS = steerAS ? FwdA : FwdB;
                end else begin
                    stateNextS = Header;
                end
            end
            FwdA: begin
                if (acceptS && holdLastR) begin
                    stateNextS = Header;
                end else begin
                    stateNextS = FwdA;
                end
            end
            FwdB: begin
                if (acceptS && holdLastR) begin
                    stateNextS = Header;
                end else begin
                    stateNextS = FwdB;
                end
            end
            default: stateNextS = Header;
        endcase
    end

    // Frame-position state register; reset drops any partial frame
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            stateR <= Header;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Holding-stage valid flag; it reloads whenever the stage is not stalled
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            holdReadyR <= 1'b0;
        end else if (!stallS) begin
            holdReadyR <= smiInReady;
        end else begin
            holdReadyR <= holdReadyR;
        end
    end

    // Holding-stage datapath (no reset); eofc is masked on the way in
    always_ff @(posedge clk) begin
        if (!stallS) begin
            holdEofcR <= smiInEofc & EofcMaskBits;
            holdDataR <= smiInData;
            holdLastR <= (smiInEofc != 8'd0);
        end else begin
            holdEofcR <= holdEofcR;
            holdDataR <= holdDataR;
            holdLastR <= holdLastR;
        end
    end

    // Output stage valid flags. An unselected port loads an empty slot, so it
    // never shows the current held flit.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            outAReadyR <= 1'b0;
            outBReadyR <= 1'b0;
        end else begin
            if (loadAS) begin
                outAReadyR <= holdReadyR & steerAS;
            end else begin
                outAReadyR <= outAReadyR;
            end
            if (loadBS) begin
                outBReadyR <= holdReadyR & ~steerAS;
            end else begin
                outBReadyR <= outBReadyR;
            end
        end
    end

    // Output stage datapath (no reset); it captures only flits routed to it
    always_ff @(posedge clk) begin
        if (pushAS) begin
            outAEofcR <= holdEofcR;
            outADataR <= holdDataR;
        end else begin
            outAEofcR <= outAEofcR;
            outADataR <= outADataR;
        end
        if (pushBS) begin
            outBEofcR <= holdEofcR;
            outBDataR <= holdDataR;
        end else begin
            outBEofcR <= outBEofcR;
            outBDataR <= outBDataR;
        end
    end

    // Per-port frame counters; a frame counts when its last flit enters the
    // output stage. The counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            frameCountAR <= 16'd0;
            frameCountBR <= 16'd0;
        end else begin
            if (pushAS && holdLastR) begin
                frameCountAR <= frameCountAR + 16'd1;
            end else begin
                frameCountAR <= frameCountAR;
            end
            if (pushBS && holdLastR) begin
                frameCountBR <= frameCountBR + 16'd1;
            end else begin
                frameCountBR <= frameCountBR;
            end
        end
    end

    assign smiInStop    = stallS;
    assign smiOutAReady = outAReadyR;
    assign smiOutAEofc  = outAEofcR;
    assign smiOutAData  = outADataR;
    assign smiOutBReady = outBReadyR;
    assign smiOutBEofc  = outBEofcR;
    assign smiOutBData  = outBDataR;
    assign frameCountA  = frameCountAR;
    assign frameCountB  = frameCountBR;

endmodule

// File: tb/tb_smi_frame_steer_x2.sv
// Testbench for smi_frame_steer_x2. A frame-level reference model keeps one
// queue of expected flits per port, and a cycle loop compares the DUT outputs
// against those queues.

module tb_smi_frame_steer_x2;

    localparam int         DW   = 16;
    localparam logic [7:0] MASK = 8'h03;

    logic          clk;
    logic          arstn;
    logic          smiInReady;
    logic [7:0]    smiInEofc;
    logic [DW-1:0] smiInData;
    logic          smiInStop;
    logic          smiOutAReady;
    logic [7:0]    smiOutAEofc;
    logic [DW-1:0] smiOutAData;
    logic          smiOutAStop;
    logic          smiOutBReady;
    logic [7:0]    smiOutBEofc;
    logic [DW-1:0] smiOutBData;
    logic          smiOutBStop;
    logic [15:0]   frameCountA;
    logic [15:0]   frameCountB;

    smi_frame_steer_x2 #(.FlitWidth(2), .SelectBit(0)) dut (
        .clk          (clk),
        .arstn        (arstn),
        .smiInReady   (smiInReady),
        .smiInEofc    (smiInEofc),
        .smiInData    (smiInData),
        .smiInStop    (smiInStop),
        .smiOutAReady (smiOutAReady),
        .smiOutAEofc  (smiOutAEofc),
        .smiOutAData  (smiOutAData),
        .smiOutAStop  (smiOutAStop),
        .smiOutBReady (smiOutBReady),
        .smiOutBEofc  (smiOutBEofc),
        .smiOutBData  (smiOutBData),
        .smiOutBStop  (smiOutBStop),
        .frameCountA  (frameCountA),
        .frameCountB  (frameCountB)
    );

    typedef struct {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    typedef struct {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
        int            ts;
    } exp_t;

    flit_t       stimQ[$];
    exp_t        expA[$];
    exp_t        expB[$];
    logic [15:0] cntA;
    logic [15:0] cntB;
    bit          inFrame;
    bit          curB;
    int          total;
    int          bad;
    int          cyc;
    int          aFrom, aTo, bFrom, bTo;
    bit          sawStop;
    bit          bDrain;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushFlit(input logic [7:0] eofc, input logic [DW-1:0] data);
        flit_t f;
        f.eofc = eofc;
        f.data = data;
        stimQ.push_back(f);
    endtask

    // Header bit0 selects the port; later flits carry the opposite bit0.
    task automatic addFrame(input int len, input bit toB, input logic [7:0] lastEofc);
        for (int i = 0; i < len; i++) begin
            logic [DW-1:0] d;
            d = DW'($urandom);
            d[0] = (i == 0) ? toB : ~toB;
            pushFlit((i == len - 1) ? lastEofc : 8'h00, d);
        end
    endtask

    // Reference model: one accepted input flit goes to its port queue
    task automatic modelAccept(input flit_t f);
        exp_t e;
        if (!inFrame) curB = f.data[0];
        e.eofc = f.eofc & MASK;
        e.data = f.data;
        e.ts   = cyc;
        if (curB) expB.push_back(e);
        else      expA.push_back(e);
        if (f.eofc != 8'h00) begin
            if (curB) cntB++;
            else      cntA++;
            inFrame = 1'b0;
        end else begin
            inFrame = 1'b1;
        end
    endtask

    task automatic checkPort(input bit isB, input int mode, input logic rdy, input logic stp,
                             input logic [7:0] eofc, input logic [DW-1:0] data);
        exp_t  h;
        int    n;
        string nm;
        nm = isB ? "B" : "A";
        n  = isB ? expB.size() : expA.size();
        if (n > 0) h = isB ? expB[0] : expA[0];
        if (mode == 0) begin
            checkVal({nm, " ready timing"}, 32'(rdy), 32'((n > 0) && (h.ts + 2 == cyc)));
        end else if (n == 0) begin
            checkVal({nm, " spurious ready"}, 32'(rdy), 32'd0);
        end
        if (rdy && !stp && n > 0) begin
            checkVal({nm, " eofc"}, 32'(eofc), 32'(h.eofc));
            checkVal({nm, " data"}, 32'(data), 32'(h.data));
            if (isB) void'(expB.pop_front());
            else     void'(expA.pop_front());
        end
    endtask

    // One cycle: drive at the falling edge, then check outputs and transfers
    // that the next rising edge will perform.
    task automatic stepCycle(input int mode);
        @(negedge clk);
        cyc++;
        case (mode)
            0: begin
                smiOutAStop = 1'b0;
                smiOutBStop = 1'b0;
            end
            1: begin
                smiOutAStop = ($urandom_range(0, 9) < 3);
                smiOutBStop = ($urandom_range(0, 9) < 3);
            end
            default: begin
                smiOutAStop = (cyc >= aFrom && cyc < aTo);
                smiOutBStop = (cyc >= bFrom && cyc < bTo);
            end
        endcase
        if (stimQ.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
            smiInReady = 1'b1;
            smiInEofc  = stimQ[0].eofc;
            smiInData  = stimQ[0].data;
        end else begin
            smiInReady = 1'b0;
            smiInEofc  = 8'($urandom);
            smiInData  = DW'($urandom);
        end
        #1;
        checkPort(1'b0, mode, smiOutAReady, smiOutAStop, smiOutAEofc, smiOutAData);
        checkPort(1'b1, mode, smiOutBReady, smiOutBStop, smiOutBEofc, smiOutBData);
        if (mode == 0) checkVal("in stop idle", 32'(smiInStop), 32'd0);
        if (mode == 2) begin
            if (smiInStop) sawStop = 1'b1;
            if (smiOutAStop && smiOutBReady && !smiOutBStop) bDrain = 1'b1;
        end
        if (smiInReady && !smiInStop) modelAccept(stimQ.pop_front());
    endtask

    task automatic runPhase(input int mode, input int budget);
        int k;
        k = 0;
        while ((stimQ.size() + expA.size() + expB.size()) > 0 && k < budget) begin
            stepCycle(mode);
            k++;
        end
        checkVal("phase drained", 32'(stimQ.size() + expA.size() + expB.size()), 32'd0);
        checkVal("frameCountA", 32'(frameCountA), 32'(cntA));
        checkVal("frameCountB", 32'(frameCountB), 32'(cntB));
    endtask

    initial begin
        int c0;
        total = 0; bad = 0; cyc = 0;
        cntA = 16'd0; cntB = 16'd0; inFrame = 1'b0; curB = 1'b0;
        aFrom = 0; aTo = 0; bFrom = 0; bTo = 0; sawStop = 1'b0; bDrain = 1'b0;
        arstn = 1'b0; smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = '0;
        smiOutAStop = 1'b0; smiOutBStop = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkVal("reset A ready", 32'(smiOutAReady), 32'd0);
        checkVal("reset B ready", 32'(smiOutBReady), 32'd0);
        checkVal("reset in stop", 32'(smiInStop), 32'd0);
        checkVal("reset countA", 32'(frameCountA), 32'd0);
        checkVal("reset countB", 32'(frameCountB), 32'd0);
        arstn = 1'b1;

        // Single-flit frame to A
        pushFlit(8'h02, 16'h0000);
        runPhase(0, 50);
        checkVal("single countA", 32'(frameCountA), 32'd1);
        checkVal("single countB", 32'(frameCountB), 32'd0);

        // 4-flit frame to B; later flits have bit0=0
        pushFlit(8'h00, 16'h0001);
        pushFlit(8'h00, 16'hABC2);
        pushFlit(8'h00, 16'h1234);
        pushFlit(8'h01, 16'h5678);
        runPhase(0, 50);
        checkVal("4flit countB", 32'(frameCountB), 32'd1);
        checkVal("4flit countA", 32'(frameCountA), 32'd1);

        // Back-to-back A(3), B(2), A(1)
        addFrame(3, 1'b0, 8'h01);
        addFrame(2, 1'b1, 8'h02);
        addFrame(1, 1'b0, 8'h03);
        runPhase(0, 50);

        // Stage B preloaded and stopped, then port A stopped for 5 cycles
        c0 = cyc + 1;
        pushFlit(8'h01, 16'h0011);
        addFrame(6, 1'b0, 8'h01);
        aFrom = c0 + 3; aTo = c0 + 8;
        bFrom = c0 + 2; bTo = c0 + 5;
        sawStop = 1'b0; bDrain = 1'b0;
        runPhase(2, 200);
        checkVal("A stall raises in stop", 32'(sawStop), 32'd1);
        checkVal("B drains during A stall", 32'(bDrain), 32'd1);

        // eofc=0xFF on the last flit is seen as 0x03 at the output
        pushFlit(8'h00, 16'h0100);
        pushFlit(8'hFF, 16'hBEEF);
        runPhase(0, 50);

        // Random back-to-back frames, no backpressure
        for (int i = 0; i < 20; i++) begin
            addFrame($urandom_range(1, 4), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)));
        end
        runPhase(0, 500);

        // Random frames, random gaps and random backpressure
        for (int i = 0; i < 80; i++) begin
            addFrame($urandom_range(1, 5), 1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)));
        end
        runPhase(1, 5000);

        // Asynchronous reset in the middle of an A frame
        addFrame(5, 1'b0, 8'h01);
        repeat (3) stepCycle(0);
        stimQ.delete();
        smiInReady = 1'b0;
        #2 arstn = 1'b0;
        #1;
        checkVal("async reset A ready", 32'(smiOutAReady), 32'd0);
        checkVal("async reset B ready", 32'(smiOutBReady), 32'd0);
        checkVal("async reset countA", 32'(frameCountA), 32'd0);
        checkVal("async reset countB", 32'(frameCountB), 32'd0);
        checkVal("async reset in stop", 32'(smiInStop), 32'd0);
        expA.delete();
        expB.delete();
        cntA = 16'd0; cntB = 16'd0; inFrame = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
        pushFlit(8'h01, 16'h0001);
        runPhase(0, 50);
        checkVal("post reset countB", 32'(frameCountB), 32'd1);
        checkVal("post reset countA", 32'(frameCountA), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/smi_frame_steer_x2.md
SMI_FRAME_STEER_X2 -- requirements
Module: smi_frame_steer_x2

Interface
REQ-001 SHALL have parameter FlitWidth, default 2, meaning SMI flit width in bytes.
REQ-002 SHALL have parameter EofcMask, default 2*FlitWidth-1, meaning mask applied to forwarded end of frame control bits.
REQ-003 SHALL have parameter SelectBit, default 0, meaning bit index of first-flit data that selects the destination port.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port arstn  input  1  meaning asynchronous active-low reset.
REQ-006 SHALL have port smiInReady  input  1  meaning input flit valid.
REQ-007 SHALL have port smiInEofc  input  8  meaning input end of frame control; nonzero marks last flit of frame.
REQ-008 SHALL have port smiInData  input  FlitWidth*8  meaning input flit data.
REQ-009 SHALL have port smiInStop  output  1  meaning backpressure to upstream.
REQ-010 SHALL have ports smiOutAReady/smiOutBReady  output  1  meaning output flit valid, per port.
REQ-011 SHALL have ports smiOutAEofc/smiOutBEofc  output  8  meaning output end of frame control, per port.
REQ-012 SHALL have ports smiOutAData/smiOutBData  output  FlitWidth*8  meaning output flit data, per port.
REQ-013 SHALL have ports smiOutAStop/smiOutBStop  input  1  meaning backpressure from downstream, per port.
REQ-014 SHALL have ports frameCountA/frameCountB  output  16  meaning count of complete frames forwarded per port.

Function
REQ-015 SHALL transfer a flit on any SMI link in a cycle where Ready=1 and Stop=0 at the rising edge.
REQ-016 SHALL register input in a holding stage (ready, eofc masked with EofcMask, data, last = eofc!=0) loaded whenever holding stage is not stalled.
REQ-017 SHALL drive smiInStop = holding ready & halt, halt = selected output stage is full and its Stop is 1 (combinational from registers and Stop inputs only).
REQ-018 SHALL register each output port in a single output stage loaded when ~(OutReady & OutStop); smiOut* driven directly from these registers.
REQ-019 SHALL implement states Header, FwdA, FwdB; reset state Header.
REQ-020 SHALL in Header, with held flit valid, steer it to A if data[SelectBit]=0, else B, in the same cycle.
REQ-021 SHALL in Header on accepted non-last flit go to FwdA/FwdB per steer; on accepted last flit (single-flit frame) remain in Header.
REQ-022 SHALL in FwdA/FwdB forward all held flits to that port regardless of data bits; on accepted last flit return to Header.
REQ-023 SHALL never drive OutReady on the non-selected port from the current held flit.
REQ-024 SHALL give latency of exactly 2 cycles from input transfer to output Ready with no backpressure, sustaining 1 flit/cycle.
REQ-025 SHALL let a stalled port block only the input; the other output stage SHALL continue to drain independently.
REQ-026 SHALL allow back-to-back frames to alternate ports with no idle cycle between them.
REQ-027 SHALL increment frameCountX by 1 when a last flit is loaded into output stage X; wrap 0xFFFF -> 0x0000.
REQ-028 SHALL pass data and masked eofc unmodified; a flit never duplicated or dropped.

Reset
REQ-029 SHALL on arstn=0 asynchronously clear state to Header, holding ready, both output Ready, and both frame counters to 0; smiInStop therefore 0.
REQ-030 SHALL leave datapath registers (eofc, data) without reset.
REQ-031 SHALL discard any partial frame in flight on reset; first flit after reset is treated as a header.

Verification
REQ-032 SHALL verify: single-flit frame, data=0x0000, eofc=0x02 -> smiOutAReady=1 two cycles later with eofc 0x02, data 0x0000; frameCountA=1; B silent.
REQ-033 SHALL verify: 4-flit frame, first data=0x0001, later flits bit0=0, eofc=0x01 on last -> all 4 flits on B in order, frameCountB=1, A silent.
REQ-034 SHALL verify: frames A(3 flits), B(2), A(1) back-to-back with no gaps -> smiInStop stays 0, each port receives its flits with no bubble between frames.
REQ-035 SHALL verify: smiOutAStop=1 for 5 cycles during an A frame -> smiInStop=1 after output and holding stages fill, no loss, B stage (pre-loaded) still drains.
REQ-036 SHALL verify: eofc=0xFF on last flit, FlitWidth=2 -> output eofc=0x03.
REQ-037 SHALL verify: arstn pulled low mid-frame (async, between edges) -> all Ready and counters 0 immediately; next flit with bit0=1 routes to B.
